// File: rtl/riskproc_pkg.sv
// ============================================================================
// Module   : riskproc_pkg
// Purpose  : Shared constants for the riskproc machine timer and its users.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riskproc_pkg;

    // Register offsets from the timer base address
    localparam logic [3:0]  MTIME_LO       = 4'h0;
    localparam logic [3:0]  MTIME_HI       = 4'h4;
    localparam logic [3:0]  MTIMECMP_LO    = 4'h8;
    localparam logic [3:0]  MTIMECMP_HI    = 4'hC;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] MCAUSE_MTI     = 32'h8000_0007;

    function automatic logic [3:0] reg_offset(input logic [1:0] word_sel);
        return {word_sel, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/machine_timer_if.sv
// ============================================================================
// Module   : machine_timer_if
// Purpose  : 32-bit load/store path between the core and the machine timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface machine_timer_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        W;
    logic        load;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output addr, wdata, W, load,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, wdata, W, load,
        output rdata, rvalid
    );

endinterface

`default_nettype wire

// File: rtl/mtimer_prescaler.sv
// ============================================================================
// Module   : mtimer_prescaler
// Purpose  : 16-bit divider producing one mtime tick every PRESCALE cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtimer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  clear,
    output logic tick
);

    localparam logic [15:0] TERMINAL = 16'(PRESCALE - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        tick    = (count_q == TERMINAL);
        count_d = count_q + 16'd1;
        // A clear restarts the period so the next tick is a full PRESCALE away
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/machine_timer.sv
// ============================================================================
// Module   : machine_timer
// Purpose  : RISC-V mtime/mtimecmp timer with registered time_compare level.
//            Optional prescaler enabled by defining MTIMER_PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module machine_timer
    import riskproc_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'hFFFF_0000,
    parameter int          PRESCALE = 1
) (
    input  wire                 clk,
    input  wire                 reset,
    machine_timer_if.slave      bus,
    output logic                time_compare,
    output logic [63:0]         mtime
);

    generate
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("machine_timer: PRESCALE must be within 1..65535");
        end
    endgenerate

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        time_compare_q, time_compare_d;

    logic        sel;
    logic        wr;
    logic        rd;
    logic        tick;
    logic [3:0]  off;

    assign off = reg_offset(bus.addr[3:2]);
    assign sel = (bus.addr[31:4] == BASE[31:4]) && (bus.addr[1:0] == 2'b00);
    assign wr  = sel && bus.W;
    assign rd  = sel && bus.load && !bus.W;

`ifdef MTIMER_PRESCALE_EN
    mtimer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (wr && (off == MTIME_LO || off == MTIME_HI)),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        // Increment first; a store then overrides only the half it addresses
        mtime_d        = tick ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d     = mtimecmp_q;
        hi_shadow_d    = hi_shadow_q;
        rdata_d        = rdata_q;
        rvalid_d       = rd;
        time_compare_d = (mtime_q >= mtimecmp_q);

        if (wr) begin
            case (off)
                MTIME_LO:    mtime_d[31:0]     = bus.wdata;
                MTIME_HI:    mtime_d[63:32]    = bus.wdata;
                MTIMECMP_LO: mtimecmp_d[31:0]  = bus.wdata;
                default:     mtimecmp_d[63:32] = bus.wdata;
            endcase
        end

        if (rd) begin
            case (off)
                MTIME_LO: begin
                    rdata_d     = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                MTIME_HI:    rdata_d = hi_shadow_q;
                MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                default:     rdata_d = mtimecmp_q[63:32];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q        <= '0;
            mtimecmp_q     <= MTIMECMP_RESET;
            hi_shadow_q    <= '0;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
            time_compare_q <= 1'b0;
        end else begin
            mtime_q        <= mtime_d;
            mtimecmp_q     <= mtimecmp_d;
            hi_shadow_q    <= hi_shadow_d;
            rdata_q        <= rdata_d;
            rvalid_q       <= rvalid_d;
            time_compare_q <= time_compare_d;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign time_compare = time_compare_q;
    assign mtime        = mtime_q;

endmodule

`default_nettype wire

// File: tb/tb_machine_timer.sv
// ============================================================================
// Module   : tb_machine_timer
// Purpose  : Self-checking bench for machine_timer against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_machine_timer;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] OTHER = 32'h1234_0000;
`ifdef MTIMER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        time_compare;
    logic [63:0] mtime;

    machine_timer_if bus ();

    machine_timer #(
        .BASE     (BASE),
        .PRESCALE (PS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .time_compare (time_compare),
        .mtime        (mtime)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_tc;
    int          m_pcnt;

    task automatic model_step(input logic [31:0] a, input logic [31:0] d,
                              input logic w, input logic ld, input logic rs);
        logic        s, wr, rd, tk;
        logic [3:0]  off;
        logic [63:0] nt;
        if (rs) begin
            m_time = '0; m_cmp = '1; m_shadow = '0; m_rdata = '0;
            m_rvalid = 1'b0; m_tc = 1'b0; m_pcnt = 0;
            return;
        end
        s   = (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
        wr  = s && w;
        rd  = s && ld && !w;
        off = a[3:0];
        tk  = (m_pcnt == PS - 1);
        m_tc     = (m_time >= m_cmp);
        m_rvalid = rd;
        if (rd) begin
            case (off)
                4'h0: begin m_rdata = m_time[31:0]; m_shadow = m_time[63:32]; end
                4'h4: m_rdata = m_shadow;
                4'h8: m_rdata = m_cmp[31:0];
                default: m_rdata = m_cmp[63:32];
            endcase
        end
        nt = tk ? m_time + 64'd1 : m_time;
        if (wr && off == 4'h0) nt[31:0]        = d;
        if (wr && off == 4'h4) nt[63:32]       = d;
        if (wr && off == 4'h8) m_cmp[31:0]     = d;
        if (wr && off == 4'hC) m_cmp[63:32]    = d;
        m_pcnt = ((wr && (off == 4'h0 || off == 4'h4)) || tk) ? 0 : m_pcnt + 1;
        m_time = nt;
    endtask

    task automatic cycle(input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic ld, input logic rs);
        bus.addr = a; bus.wdata = d; bus.W = w; bus.load = ld; reset = rs;
        @(posedge clk);
        model_step(a, d, w, ld, rs);
        #1;
        bus.W = 1'b0; bus.load = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        total += 4;
        if (mtime !== 64'd0) begin bad++; $display("FAIL reset_mtime got %0h want 0", mtime); end
        if (time_compare !== 1'b0) begin bad++; $display("FAIL reset_tc got %b want 0", time_compare); end
        if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b want 0", bus.rvalid); end
        if (bus.rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got %0h want 0", bus.rdata); end
        for (int i = 0; i < 6 * PS; i++) begin
            cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            total++;
            if (mtime !== m_time) begin bad++; $display("FAIL count_up got %0h want %0h", mtime, m_time); end
        end
        for (int i = 0; i < 2; i++) begin
            cycle(BASE + 32'h8 + 32'(i * 4), 32'h0, 1'b0, 1'b1, 1'b0);
            total += 2;
            if (bus.rvalid !== 1'b1) begin bad++; $display("FAIL cmp_reset_rvalid got %b want 1", bus.rvalid); end
            if (bus.rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cmp_reset_val got %0h want ffffffff", bus.rdata); end
        end
        cycle(BASE, 32'h0, 1'b0, 1'b1, 1'b1);
        total += 2;
        if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL reset_mid_access rvalid got %b want 0", bus.rvalid); end
        if (mtime !== 64'd0) begin bad++; $display("FAIL reset_mid_access mtime got %0h want 0", mtime); end
    endtask

    task automatic test_compare();
        int t_ten, t_rise;
        t_ten = -1; t_rise = -1;
        cycle(BASE + 32'h4, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'hC, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'h8, 32'd10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16 * PS; i++) begin
            cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            total += 2;
            if (mtime !== m_time) begin bad++; $display("FAIL cmp_mtime got %0h want %0h", mtime, m_time); end
            if (time_compare !== m_tc) begin bad++; $display("FAIL cmp_tc got %b want %b", time_compare, m_tc); end
            if (mtime == 64'd10 && t_ten < 0) t_ten = i;
            if (time_compare === 1'b1 && t_rise < 0) t_rise = i;
        end
        total++;
        if (t_ten < 0 || t_rise != t_ten + 1) begin
            bad++; $display("FAIL tc_rise_latency got %0d want %0d", t_rise, t_ten + 1);
        end
        cycle(BASE + 32'h8, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'hC, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            total++;
            if (time_compare !== 1'b0) begin bad++; $display("FAIL tc_clear got %b want 0", time_compare); end
        end
    endtask

    task automatic test_carry_read();
        cycle(BASE + 32'h4, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'h0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < PS; i++) cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(BASE + 32'(4 * (i % 2)), 32'h0, 1'b0, 1'b1, 1'b0);
            total += 2;
            if (bus.rvalid !== 1'b1) begin bad++; $display("FAIL carry_rvalid got %b want 1", bus.rvalid); end
            if (bus.rdata !== m_rdata) begin bad++; $display("FAIL carry_rdata got %0h want %0h", bus.rdata, m_rdata); end
        end
    endtask

    task automatic test_wrap();
        cycle(BASE + 32'hC, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'h8, 32'd5, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        total++;
        if (mtime !== m_time) begin bad++; $display("FAIL wrap_store got %0h want %0h", mtime, m_time); end
        for (int i = 0; i < 10 * PS; i++) begin
            cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            total += 2;
            if (mtime !== m_time) begin bad++; $display("FAIL wrap_mtime got %0h want %0h", mtime, m_time); end
            if (time_compare !== m_tc) begin bad++; $display("FAIL wrap_tc got %b want %b", time_compare, m_tc); end
        end
    endtask

    task automatic test_unaligned();
        cycle(BASE + 32'h2, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'h6, 32'h0, 1'b0, 1'b1, 1'b0);
        total++;
        if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL unaligned_rvalid got %b want 0", bus.rvalid); end
        cycle(OTHER + 32'h8, 32'h0, 1'b0, 1'b1, 1'b0);
        total++;
        if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL other_base_rvalid got %b want 0", bus.rvalid); end
        cycle(OTHER + 32'hC, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(BASE + 32'h8 + 32'(4 * i), 32'h0, 1'b0, 1'b1, 1'b0);
            total += 2;
            if (bus.rdata !== m_rdata) begin bad++; $display("FAIL unaligned_cmp got %0h want %0h", bus.rdata, m_rdata); end
            if (mtime !== m_time) begin bad++; $display("FAIL unaligned_mtime got %0h want %0h", mtime, m_time); end
        end
    endtask

    task automatic test_prescale();
        int k;
        cycle(BASE + 32'h4, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(BASE + 32'h0, 32'd100, 1'b1, 1'b0, 1'b0);
        k = 1;
        while (k <= 20) begin
            cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            if (mtime[31:0] != 32'd100) break;
            k++;
        end
        total += 2;
        if (k != PS) begin bad++; $display("FAIL prescale_period got %0d want %0d", k, PS); end
        if (mtime[31:0] !== 32'd101) begin bad++; $display("FAIL prescale_value got %0d want 101", mtime[31:0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] offs [4];
        offs = '{32'h8, 32'hC, 32'h0, 32'h4};
        for (int i = 0; i < 4; i++) begin
            cycle(BASE + offs[i], 32'h0, 1'b0, 1'b1, 1'b0);
            total += 2;
            if (bus.rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid got %b want 1", bus.rvalid); end
            if (bus.rdata !== m_rdata) begin bad++; $display("FAIL b2b_rdata got %0h want %0h", bus.rdata, m_rdata); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        w, ld, rs;
        int          pick;
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0, 1, 2, 3: a = BASE + 32'(pick * 4);
                4:          a = BASE + 32'($urandom_range(0, 3) * 4 + $urandom_range(1, 3));
                5:          a = OTHER + 32'($urandom_range(0, 3) * 4);
                6:          a = BASE + 32'h8;
                default:    a = BASE + 32'hC;
            endcase
            d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            w  = ($urandom_range(0, 3) == 0);
            ld = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 99) == 0);
            cycle(a, d, w, ld, rs);
            total += 3;
            if (mtime !== m_time) begin bad++; $display("FAIL rand_mtime got %0h want %0h", mtime, m_time); end
            if (time_compare !== m_tc) begin bad++; $display("FAIL rand_tc got %b want %b", time_compare, m_tc); end
            if (bus.rvalid !== m_rvalid) begin bad++; $display("FAIL rand_rvalid got %b want %b", bus.rvalid, m_rvalid); end
            if (m_rvalid) begin
                total++;
                if (bus.rdata !== m_rdata) begin bad++; $display("FAIL rand_rdata got %0h want %0h", bus.rdata, m_rdata); end
            end
        end
    endtask

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.W = 1'b0; bus.load = 1'b0;
        reset = 1'b1;
        test_reset();
        test_compare();
        test_carry_read();
        test_wrap();
        test_unaligned();
        test_prescale();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer (mtime/mtimecmp) for the riskproc core. Holds a free-running 64-bit mtime counter and a 64-bit mtimecmp register, both accessible over the core's 32-bit load/store path. Produces the registered `time_compare` level consumed by the interrupt controller, which sets mip[7] and raises mcause 0x80000007.

## Interface
- `BASE`, 32'hFFFF_0000: base address; the block decodes `addr[31:4] == BASE[31:4]`.
- `PRESCALE`, 1: mtime increment period in clk cycles; legal range 1..65535. Used only with `MTIMER_PRESCALE_EN`.

- `clk`  in  1: core clock.
- `reset`  in  1: synchronous, active-high reset.
- `addr`  in  32: byte address of the load/store.
- `wdata`  in  32: store data.
- `W`  in  1: store strobe, one cycle per store.
- `load`  in  1: load strobe, one cycle per load.
- `rdata`  out  32: load data, registered.
- `rvalid`  out  1: one-cycle pulse; `rdata` is valid.
- `time_compare`  out  1: registered `mtime >= mtimecmp` (unsigned).
- `mtime`  out  64: current counter value, for the time/timeh CSRs.

## Operation
- Register map (offset from `BASE`):
  - 0x0: mtime_lo
  - 0x4: mtime_hi
  - 0x8: mtimecmp_lo
  - 0xC: mtimecmp_hi
- Word access only. Accesses with `addr[1:0] != 0` or `addr[3:2]` unmapped are ignored: no write, no `rvalid`. Misalignment traps belong to the interrupt controller.
- Store: `W=1` and selected writes `wdata` to the addressed half in the same edge. The other half is unchanged.
- Load: `load=1`, `W=0` and selected.
  - `rdata`/`rvalid` are presented on the next cycle.
  - Reading mtime_lo also latches mtime_hi into the 32-bit `hi_shadow`.
  - Reading mtime_hi returns `hi_shadow`, giving a coherent lo-then-hi read across the carry.
  - mtimecmp reads are direct.
- If `load` and `W` are both 1, the access is treated as a store only.
- Increment: on each tick, `mtime <= mtime + 1` as a full 64-bit add. 2^64-1 wraps to 0.
- Store to mtime_lo/hi coinciding with a tick: the store wins for the written half. The other half still takes its incremented value, including any carry from the pre-write low half.
- `time_compare <= (mtime >= mtimecmp)`, unsigned 64-bit, evaluated on the register values before the edge.
  - It is a level and stays high until software raises mtimecmp or mtime wraps.
- Reset values:
  - mtime = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt after reset.
  - `hi_shadow` = 0, `rdata` = 0, `rvalid` = 0, `time_compare` = 0, prescaler count = 0.
- Reset asserted mid-access discards the access; `rvalid` is 0 on the following cycle.

## Timing
- Load latency: 1 cycle (strobe at edge N, `rdata`/`rvalid` valid after edge N+1). Back-to-back loads are legal, one per cycle.
- Store latency: 0. The register has its new value after the strobe edge; a load in the next cycle returns it.
- `time_compare` latency: 1 cycle after the mtime/mtimecmp change that satisfies the compare.
- Counter: without prescale, mtime increments on every edge where `reset=0`.

## Configuration
- `MTIMER_PRESCALE_EN` defined:
  - A 16-bit counter runs 0..PRESCALE-1; a tick occurs when it equals PRESCALE-1, then it returns to 0.
  - `PRESCALE=1` gives a tick every cycle.
  - A store to mtime_lo/hi clears the counter, so the next tick is a full PRESCALE cycles later.
- Undefined: tick every cycle; `PRESCALE` is ignored and no prescaler logic is synthesized.

## Structure
- Shared package `riskproc_pkg`:
  - register offsets `MTIME_LO`, `MTIME_HI`, `MTIMECMP_LO`, `MTIMECMP_HI`
  - `MTIMECMP_RESET` constant
  - `MCAUSE_MTI = 32'h8000_0007`
- One sub-module, `mtimer_prescaler` (count, tick, clear), instantiated only under `MTIMER_PRESCALE_EN`.

## Test plan
- Reset held 3 cycles, then released → mtime reads 0,1,2… on successive cycles; mtimecmp reads 0xFFFFFFFF both halves; `time_compare=0`.
- Store mtimecmp_hi=0, then mtimecmp_lo=10 → `time_compare` rises exactly one cycle after mtime becomes 10; storing mtimecmp_lo=0xFFFFFFFF, mtimecmp_hi=0xFFFFFFFF clears it one cycle later.
- Store mtime_hi=0, mtime_lo=0xFFFFFFFE, then read lo then hi across the carry → lo=0xFFFFFFFF, hi=0 (shadow); a fresh lo/hi pair read afterwards gives hi=1.
- Store mtime_hi=mtime_lo=0xFFFFFFFF → next tick mtime=0; `time_compare` with mtimecmp=5 rises again at mtime=5.
- Store to BASE+0x2 and load from BASE+0x6 → no register changes, `rvalid` stays 0.
- With `MTIMER_PRESCALE_EN`, PRESCALE=4 → mtime advances once per 4 cycles; storing mtime_lo=100 yields 101 exactly 4 cycles later.
